rv_irq_ctrl: RTL and testbench
==============================

# rv_irq_ctrl

Interrupt controller for the rv_sopc system. It merges one internal periodic timer and NSRC-1 external edge-triggered sources onto the single CPU `irq` line. It holds pending and enable state, and arbitrates among pending sources by fixed priority through a claim register. It is a Wishbone B4 classic slave on the SoC data bus and replaces the free-running external irq pulse generator.

## Interface
- `NSRC`, 4: number of interrupt sources including timer (source 0); range 2..32
- `TIMER_W`, 16: timer counter/period width; range 1..32

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low
- `wb_adr_i`  in  3  word address (register index)
- `wb_dat_i`  in  32  write data
- `wb_we_i`  in  1  write enable
- `wb_cyc_i`  in  1  bus cycle
- `wb_stb_i`  in  1  strobe
- `wb_dat_o`  out  32  read data, valid with `wb_ack_o`
- `wb_ack_o`  out  1  single-cycle acknowledge
- `src_i`  in  NSRC-1  external sources, already synchronous to `clk`; bit k maps to source k+1
- `irq`  out  1  interrupt request to CPU, level

## Operation
- Registers (index: name):
  - 0 PENDING: RW1C
  - 1 ENABLE: RW
  - 2 PERIOD: RW, low TIMER_W bits
  - 3 CTRL: bit0 timer enable, RW
  - 4 COUNT: RO, timer value
  - 5 CLAIM: RO with side effect
  - 6-7: read 0, writes ignored
  - Unused upper bits read 0.
- Edge detect: `src_q <= src_i`. Rising edge of source k+1 sets PENDING[k+1].
- Timer:
  - When CTRL.en=1 and PERIOD≠0, COUNT increments each cycle.
  - At COUNT==PERIOD it wraps to 0 and sets PENDING[0]. This gives a tick every PERIOD+1 cycles.
  - CTRL.en=0 or PERIOD=0 holds COUNT.
  - Writing CTRL or PERIOD clears COUNT to 0.
- CLAIM read returns {valid in bit31, id in bits4:0}.
  - id is the lowest index k with PENDING[k]&ENABLE[k].
  - On a valid read, PENDING[id] is cleared in the ack cycle.
  - With no such source, CLAIM returns 0.
- Simultaneous set and clear (edge/tick vs W1C or claim) on the same bit: set wins, and the bit stays pending.
- `irq` is registered `|(PENDING & ENABLE)`.
- Reset state:
  - PENDING, ENABLE, PERIOD, CTRL, COUNT, `src_q`: 0
  - `wb_ack_o`, `irq`, `wb_dat_o`: 0
  - A source held high through reset produces no edge.

## Timing
- Bus:
  - `wb_ack_o` asserts the cycle after `cyc&stb` is sampled with ack low.
  - It stays high exactly one cycle and is never asserted back-to-back. Every access takes 2 cycles minimum.
  - Register side effects (write, W1C, claim clear) commit on the ack edge.
- Read data is sampled from register state on the request cycle.
- Source latency:
  - Rising edge first sampled high at edge E.
  - PENDING set at E+1.
  - `irq` high at E+2.
- Timer latency: the tick cycle (COUNT==PERIOD) sets PENDING at the next edge, and `irq` follows one cycle later.
- Clearing the last enabled pending bit drops `irq` one cycle after the clear commits.
- Reset mid-transaction: ack is dropped and the access is lost. The master must retry.

## Structure
- Shared package `rv_irq_pkg`:
  - register index constants (IRQ_PENDING..IRQ_CLAIM)
  - CLAIM valid bit position
  - CTRL bit positions
- Sub-module `rv_irq_timer`: COUNT/PERIOD compare, tick output.
- Everything else stays in `rv_irq_ctrl`, including:
  - priority encoder (a for-loop from the high index down)
  - edge detect
  - bus decode

## Test plan
- Timer: PERIOD=9999, ENABLE=1, CTRL=1. Required: `irq` rises every 10000 cycles (first at 10001 cycles after the CTRL ack). W1C PENDING=1 drops `irq` 1 cycle after the ack.
- Edge: pulse `src_i[0]` high for 1 cycle with ENABLE=0x2. Required: PENDING=0x2 and `irq` 2 cycles after. Holding `src_i[0]` high for 100 cycles after a W1C clear gives no re-trigger.
- Arbitration: sources 3 and 1 pending, ENABLE=0xF. Required:
  - first CLAIM read returns 0x80000001
  - second returns 0x80000003
  - third returns 0x00000000
  - `irq` low after the second claim.
- Mask: source 2 pending, ENABLE=0. Required: `irq`=0 and CLAIM reads 0. Writing ENABLE=0x4 raises `irq` 1 cycle after the ack.
- Collision: W1C of bit 1 committed on the same edge as a new rising edge of source 1. Required: PENDING[1] stays 1.
- Reset: assert `rst`=0 mid-access with timer running. Required: next cycle ack=0, `irq`=0, all registers 0, COUNT frozen at 0.

Source files
------------

// File: rtl/rv_irq_pkg.sv
// rv_irq_pkg: shared constants for the rv_sopc interrupt controller.
//   - register indices on the 3-bit Wishbone word address
//   - bit position of the valid flag in the CLAIM read value
//   - bit positions inside CTRL
package rv_irq_pkg;

    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ENABLE  = 3'd1;
    localparam logic [2:0] IRQ_PERIOD  = 3'd2;
    localparam logic [2:0] IRQ_CTRL    = 3'd3;
    localparam logic [2:0] IRQ_COUNT   = 3'd4;
    localparam logic [2:0] IRQ_CLAIM   = 3'd5;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int CLAIM_ID_W      = 5;

    localparam int CTRL_EN_BIT = 0;

endpackage

// File: rtl/rv_irq_timer.sv
// rv_irq_timer: periodic tick source (interrupt source 0).
//   clk, rst    : clock, synchronous active-low reset
//   en          : timer enable (CTRL.en)
//   period      : compare value; 0 freezes the counter
//   clr         : clears the counter (a write to PERIOD or CTRL committed)
//   count       : current counter value
//   tick        : high during the cycle in which count == period while running
module rv_irq_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [TIMER_W-1:0] period,
    input  logic               clr,
    output logic [TIMER_W-1:0] count,
    output logic               tick
);

    logic running;

    assign running = en && (period != '0);
    // count runs 0..period inclusive, so a tick occurs every period+1 cycles
    assign tick    = running && (count == period);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (running) begin
            if (count == period) count <= '0;
            else                 count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_irq_ctrl.sv
// rv_irq_ctrl: interrupt controller for rv_sopc.
// Merges the internal timer (source 0) and NSRC-1 rising-edge external
// sources into one level irq, with pending/enable registers and a
// fixed-priority CLAIM register (lowest index wins).
//   clk, rst            : clock, synchronous active-low reset
//   wb_adr_i..wb_stb_i  : Wishbone B4 classic slave inputs
//   wb_dat_o, wb_ack_o  : read data (valid with ack), single-cycle ack
//   src_i               : external sources, bit k is source k+1
//   irq                 : registered |(PENDING & ENABLE)
//
// Handshake: a request is cyc&stb sampled while ack is low. The edge that
// samples it raises ack for exactly one cycle, latches read data from the
// register state of the request cycle and commits every side effect
// (write, W1C, claim clear). Ack is never back-to-back, so an access costs
// at least two cycles.
module rv_irq_ctrl
    import rv_irq_pkg::*;
#(
    parameter int NSRC    = 4,
    parameter int TIMER_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [31:0]     wb_dat_o,
    output logic            wb_ack_o,
    input  logic [NSRC-2:0] src_i,
    output logic            irq
);

    logic [NSRC-1:0]       pend_q, en_q;
    logic [TIMER_W-1:0]    period_q;
    logic                  ctrl_en_q;
    logic [TIMER_W-1:0]    count;
    logic                  tick;
    logic [NSRC-2:0]       src_q, edge_q;
    logic                  armed_q;

    logic                  req, wr, rd, timer_clr;
    logic [NSRC-1:0]       active, claim_oh, set_mask, clr_mask;
    logic                  claim_valid;
    logic [CLAIM_ID_W-1:0] claim_id;
    logic [31:0]           rdata;
    logic                  unused_dat;

    assign unused_dat = ^wb_dat_i;

    assign req       = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wr        = req && wb_we_i;
    assign rd        = req && !wb_we_i;
    assign timer_clr = wr && (wb_adr_i == IRQ_PERIOD || wb_adr_i == IRQ_CTRL);

    rv_irq_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl_en_q),
        .period (period_q),
        .clr    (timer_clr),
        .count  (count),
        .tick   (tick)
    );

    // Priority encoder: scanning from the top down lets the lowest active
    // index overwrite everything above it.
    always_comb begin
        active      = pend_q & en_q;
        claim_valid = |active;
        claim_id    = '0;
        claim_oh    = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (active[k]) begin
                claim_id    = CLAIM_ID_W'(k);
                claim_oh    = '0;
                claim_oh[k] = 1'b1;
            end
        end
    end

    // Clears first, sets last: a set on the same edge always wins.
    always_comb begin
        set_mask = {edge_q, tick};
        clr_mask = '0;
        if (wr && wb_adr_i == IRQ_PENDING) clr_mask = wb_dat_i[NSRC-1:0];
        if (rd && wb_adr_i == IRQ_CLAIM)   clr_mask = clr_mask | claim_oh;
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            IRQ_PENDING: rdata[NSRC-1:0]    = pend_q;
            IRQ_ENABLE:  rdata[NSRC-1:0]    = en_q;
            IRQ_PERIOD:  rdata[TIMER_W-1:0] = period_q;
            IRQ_CTRL:    rdata[CTRL_EN_BIT] = ctrl_en_q;
            IRQ_COUNT:   rdata[TIMER_W-1:0] = count;
            IRQ_CLAIM: begin
                rdata[CLAIM_VALID_BIT]  = claim_valid;
                rdata[CLAIM_ID_W-1:0]   = claim_id;
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            period_q  <= '0;
            ctrl_en_q <= 1'b0;
            src_q     <= '0;
            edge_q    <= '0;
            armed_q   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= rd ? rdata : '0;

            // armed_q masks the first cycle after reset, so a source already
            // high during reset is absorbed into src_q without an edge.
            src_q   <= src_i;
            edge_q  <= src_i & ~src_q & {(NSRC-1){armed_q}};
            armed_q <= 1'b1;

            pend_q <= (pend_q & ~clr_mask) | set_mask;

            if (wr) begin
                case (wb_adr_i)
                    IRQ_ENABLE: en_q      <= wb_dat_i[NSRC-1:0];
                    IRQ_PERIOD: period_q  <= wb_dat_i[TIMER_W-1:0];
                    IRQ_CTRL:   ctrl_en_q <= wb_dat_i[CTRL_EN_BIT];
                    default:    ;
                endcase
            end

            irq <= |active;
        end
    end

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// tb_rv_irq_ctrl: directed testbench for rv_irq_ctrl (NSRC=4, TIMER_W=16).
// Inputs change 1 ns after a rising edge; outputs are sampled there as well.
module tb_rv_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [2:0]  src_i;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    rv_irq_ctrl #(.NSRC(4), .TIMER_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .src_i    (src_i),
        .irq      (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the ack edge (the edge where side effects commit).
    task automatic bus_access(input logic [2:0] a, input logic we, input logic [31:0] d,
                              output logic [31:0] rd);
        bit seen = 0;
        int i = 0;
        wb_adr_i = a;
        wb_we_i  = we;
        wb_dat_i = d;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        while (!seen && i < 8) begin
            step(1);
            i++;
            if (wb_ack_o) seen = 1;
        end
        rd       = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!seen) check("ack_timeout", {31'b0, wb_ack_o}, 32'd1);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus_access(a, 1'b1, d, unused_rd);
    endtask

    task automatic bus_read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus_access(a, 1'b0, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    // Steps until irq is high or the budget runs out; n is cycles stepped.
    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (!irq && n < limit) begin
            step(1);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int c1;
        int c2;

        rst      = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        src_i    = '0;
        step(3);
        rst = 1'b1;
        step(1);

        // reset state
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        for (int r = 0; r < 8; r++) bus_read_check($sformatf("rst_reg%0d", r), 3'(r), 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read_check("reg6_ignored", 3'd6, 32'd0);

        // mask: source 2 pending with ENABLE=0
        src_i = 3'b010;
        step(1);
        src_i = 3'b000;
        step(3);
        check("mask_irq_off", {31'b0, irq}, 32'd0);
        bus_read_check("mask_pending", 3'd0, 32'h4);
        bus_read_check("mask_claim", 3'd5, 32'h0);
        bus_write(3'd1, 32'h4);
        check("mask_irq_at_ack", {31'b0, irq}, 32'd0);
        step(1);
        check("mask_irq_after_en", {31'b0, irq}, 32'd1);
        bus_write(3'd0, 32'h4);
        check("w1c_irq_at_ack", {31'b0, irq}, 32'd1);
        step(1);
        check("w1c_irq_dropped", {31'b0, irq}, 32'd0);

        // edge: 1-cycle pulse on source 1
        bus_write(3'd1, 32'h2);
        src_i = 3'b001;
        step(1);
        src_i = 3'b000;
        check("edge_irq_e0", {31'b0, irq}, 32'd0);
        step(1);
        check("edge_irq_e1", {31'b0, irq}, 32'd0);
        step(1);
        check("edge_irq_e2", {31'b0, irq}, 32'd1);
        bus_read_check("edge_pending", 3'd0, 32'h2);
        bus_write(3'd0, 32'h2);

        // held high: one edge only
        src_i = 3'b001;
        step(3);
        check("hold_irq_set", {31'b0, irq}, 32'd1);
        bus_write(3'd0, 32'h2);
        step(100);
        check("hold_no_retrig_irq", {31'b0, irq}, 32'd0);
        bus_read_check("hold_no_retrig_pend", 3'd0, 32'h0);
        src_i = 3'b000;
        step(2);

        // arbitration: sources 1 and 3
        bus_write(3'd1, 32'hF);
        src_i = 3'b101;
        step(1);
        src_i = 3'b000;
        step(3);
        bus_read_check("claim1", 3'd5, 32'h8000_0001);
        bus_read_check("claim2", 3'd5, 32'h8000_0003);
        step(1);
        check("claim_irq_low", {31'b0, irq}, 32'd0);
        bus_read_check("claim3", 3'd5, 32'h0);

        // collision: W1C of bit 1 commits on the edge that sets it
        src_i = 3'b001;
        step(1);
        bus_write(3'd0, 32'h2);
        bus_read_check("collision_pending", 3'd0, 32'h2);
        src_i = 3'b000;
        bus_write(3'd0, 32'h2);
        bus_read_check("collision_cleared", 3'd0, 32'h0);

        // timer
        bus_write(3'd1, 32'h1);
        bus_write(3'd2, 32'd9999);
        bus_read_check("period_rb", 3'd2, 32'd9999);
        bus_write(3'd3, 32'h1);
        wait_irq(20000, n);
        c1 = cyc_cnt;
        check("timer_first_irq", 32'(n), 32'd10001);
        bus_read_check("timer_pending", 3'd0, 32'h1);
        bus_write(3'd0, 32'h1);
        check("timer_w1c_at_ack", {31'b0, irq}, 32'd1);
        step(1);
        check("timer_w1c_drop", {31'b0, irq}, 32'd0);
        wait_irq(20000, n);
        c2 = cyc_cnt;
        check("timer_interval", 32'(c2 - c1), 32'd10000);

        // reset mid-access with timer running, source 1 held high
        wb_adr_i = 3'd4;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        src_i    = 3'b001;
        rst      = 1'b0;
        step(1);
        check("mid_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        bus_read_check("post_rst_pending", 3'd0, 32'h0);
        bus_read_check("post_rst_enable", 3'd1, 32'h0);
        bus_read_check("post_rst_period", 3'd2, 32'h0);
        bus_read_check("post_rst_ctrl", 3'd3, 32'h0);
        bus_read_check("post_rst_count", 3'd4, 32'h0);
        step(20);
        bus_read_check("post_rst_count_frozen", 3'd4, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'd0);
        src_i = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
